// File: rtl/bypass_fifo_arbiter_pkg.sv
// ============================================================================
// Package : bypass_arb_pkg
// Shared constants and the round-robin one-hot pick helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bypass_arb_pkg;

  localparam int MAX_REQ = 8;

  function automatic int CNT_W(input int n);
    return $clog2(n + 1);
  endfunction

  // First set bit of elig searching from ptr+1, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] elig,
    input logic [2:0]         ptr,
    input int                 n = MAX_REQ
  );
    logic [MAX_REQ-1:0] pick;
    logic [2:0]         idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (!found && elig[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bypass_fifo_arbiter_if.sv
// ============================================================================
// Interface : bypass_fifo_arbiter_if
// Requester, FIFO-enqueue and epoch signals of the bypass FIFO arbiter.
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface bypass_fifo_arbiter_if #(
  parameter int width = 0,
  parameter int n_req = 4
) ();
  import bypass_arb_pkg::*;

  logic [n_req-1:0]           REQ;
  logic [n_req*(width+1)-1:0] REQ_VALUE;
  logic [n_req-1:0]           GRANT;
  logic                       FIFO_NOT_FULL;
  logic                       FIFO_ENQ;
  logic [width:0]             FIFO_ENQ_VALUE;
  logic                       EPOCH_END;
  logic [n_req-1:0]           SERVED;
  logic                       ALL_SERVED;
  logic [CNT_W(n_req)-1:0]    EPOCH_COUNT;

  modport slave (
    input  REQ, REQ_VALUE, FIFO_NOT_FULL, EPOCH_END,
    output GRANT, FIFO_ENQ, FIFO_ENQ_VALUE, SERVED, ALL_SERVED, EPOCH_COUNT
  );

  modport master (
    output REQ, REQ_VALUE, FIFO_NOT_FULL, EPOCH_END,
    input  GRANT, FIFO_ENQ, FIFO_ENQ_VALUE, SERVED, ALL_SERVED, EPOCH_COUNT
  );

endinterface

`default_nettype wire

// File: rtl/bypass_fifo_arbiter_rr_pick.sv
// ============================================================================
// Module  : rr_pick_onehot
// Combinational rotate / priority-encode / unrotate round-robin picker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick_onehot
  import bypass_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  wire logic [N-1:0]         elig,
  input  wire logic [$clog2(N)-1:0] ptr,
  output logic      [N-1:0]         grant
);

  always_comb begin
    grant = N'(rr_pick(MAX_REQ'(elig), 3'(ptr), N));
  end

endmodule

`default_nettype wire

// File: rtl/bypass_fifo_arbiter.sv
// ============================================================================
// Module  : bypass_fifo_arbiter
// Round-robin arbiter sharing one bypass FIFO's enqueue port among n_req
// requesters. Macro BYPASS_ARB_EPOCH_ONCE_EN limits each requester to one
// enqueue per epoch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bypass_fifo_arbiter
  import bypass_arb_pkg::*;
#(
  parameter int width = 0,
  parameter int n_req = 4
) (
  input wire logic             CLK,
  input wire logic             RST,
  bypass_fifo_arbiter_if.slave bus
);

  localparam int PW = $clog2(n_req);
  localparam int CW = CNT_W(n_req);

  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [n_req-1:0] served;
  logic [n_req-1:0] mask;
  logic [n_req-1:0] elig;
  logic [n_req-1:0] pick;
  logic [n_req-1:0] grant;
  logic [CW-1:0]    cnt;
  logic [width:0]   enq_value;

`ifdef BYPASS_ARB_EPOCH_ONCE_EN
  assign mask = served;
`else
  assign mask = '0;
`endif

  assign elig = bus.REQ & ~mask;

  rr_pick_onehot #(.N(n_req)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .grant (pick)
  );

  // Reset gates the grant combinationally so a mid-cycle reset withdraws it.
  assign grant = (!RST && bus.FIFO_NOT_FULL) ? pick : '0;

  always_comb begin
    enq_value = '0;
    gidx      = '0;
    for (int i = 0; i < n_req; i++) begin
      if (grant[i]) begin
        enq_value = enq_value | bus.REQ_VALUE[i*(width+1) +: width+1];
        gidx      = PW'(i);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr    <= PW'(n_req - 1);
      served <= '0;
      cnt    <= '0;
    end else begin
      if (|grant) ptr <= gidx;
      if (bus.EPOCH_END) begin
        served <= '0;
        cnt    <= '0;
      end else if (|grant) begin
        served <= served | grant;
        if (cnt != '1) cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.GRANT          = grant;
  assign bus.FIFO_ENQ       = |grant;
  assign bus.FIFO_ENQ_VALUE = enq_value;
  assign bus.SERVED         = served;
  assign bus.ALL_SERVED     = &served;
  assign bus.EPOCH_COUNT    = cnt;

endmodule

`default_nettype wire

// File: tb/tb_bypass_fifo_arbiter.sv
// ============================================================================
// Module  : tb_bypass_fifo_arbiter
// Directed self-checking bench: a 4-requester and a 2-requester arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bypass_fifo_arbiter;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   total = 0;
  int   bad   = 0;

  bypass_fifo_arbiter_if #(.width(7), .n_req(4)) a_if ();
  bypass_fifo_arbiter_if #(.width(3), .n_req(2)) b_if ();

  bypass_fifo_arbiter #(.width(7), .n_req(4)) u_a (
    .CLK (clk),
    .RST (rst_a),
    .bus (a_if)
  );

  bypass_fifo_arbiter #(.width(3), .n_req(2)) u_b (
    .CLK (clk),
    .RST (rst_b),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    #1;
    a_if.REQ           = '0;
    a_if.EPOCH_END     = 1'b0;
    a_if.FIFO_NOT_FULL = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    #1;
  endtask

  logic [3:0]  exp_g;
  logic [7:0]  exp_v;
  logic [1:0]  exp_g2;
  logic [31:0] exp_c;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.REQ           = 4'b1111;
    a_if.REQ_VALUE     = 32'h44_33_22_11;
    a_if.FIFO_NOT_FULL = 1'b1;
    a_if.EPOCH_END     = 1'b0;
    b_if.REQ           = 2'b11;
    b_if.REQ_VALUE     = 8'hBA;
    b_if.FIFO_NOT_FULL = 1'b1;
    b_if.EPOCH_END     = 1'b0;

    // Reset state and output gating while reset is held
    #2;
    chk("rst_grant",   a_if.GRANT, 4'b0000);
    chk("rst_enq",     a_if.FIFO_ENQ, 1'b0);
    chk("rst_value",   a_if.FIFO_ENQ_VALUE, 8'h00);
    chk("rst_served",  a_if.SERVED, 4'b0000);
    chk("rst_all",     a_if.ALL_SERVED, 1'b0);
    chk("rst_count",   a_if.EPOCH_COUNT, 3'd0);

    // Reset release: grants 0,1,2,3,0
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
`ifdef BYPASS_ARB_EPOCH_ONCE_EN
      if (k == 4) exp_g = 4'b0000;
`endif
      exp_v = (exp_g == 4'b0000) ? 8'h00 : 8'(8'h11 * (k % 4 + 1));
      chk("rr_grant",  a_if.GRANT, exp_g);
      chk("rr_enq",    a_if.FIFO_ENQ, |exp_g);
      chk("rr_value",  a_if.FIFO_ENQ_VALUE, exp_v);
      chk("rr_served", a_if.SERVED, (32'd1 << k) - 1);
      chk("rr_all",    a_if.ALL_SERVED, k == 4);
      chk("rr_count",  a_if.EPOCH_COUNT, k);
      if (k < 4) next();
    end

    // Full FIFO: nothing granted, state holds; release grants requester 0
    reset_a();
    a_if.FIFO_NOT_FULL = 1'b0;
    a_if.REQ           = 4'b0101;
    #1;
    chk("full_grant", a_if.GRANT, 4'b0000);
    chk("full_enq",   a_if.FIFO_ENQ, 1'b0);
    chk("full_value", a_if.FIFO_ENQ_VALUE, 8'h00);
    next();
    next();
    chk("full_served", a_if.SERVED, 4'b0000);
    chk("full_count",  a_if.EPOCH_COUNT, 3'd0);
    a_if.FIFO_NOT_FULL = 1'b1;
    #1;
    chk("rel_grant", a_if.GRANT, 4'b0001);
    chk("rel_value", a_if.FIFO_ENQ_VALUE, 8'h11);
    next();
    chk("rel_served", a_if.SERVED, 4'b0001);
    chk("rel_grant2", a_if.GRANT, 4'b0100);
    chk("rel_value2", a_if.FIFO_ENQ_VALUE, 8'h33);

    // Epoch behaviour with REQ=0011 held
    reset_a();
    a_if.REQ = 4'b0011;
    #1;
    chk("ep_g1", a_if.GRANT, 4'b0001);
    next();
    chk("ep_g2", a_if.GRANT, 4'b0010);
    chk("ep_served1", a_if.SERVED, 4'b0001);
    next();
    chk("ep_served2", a_if.SERVED, 4'b0011);
    chk("ep_count2",  a_if.EPOCH_COUNT, 3'd2);
`ifdef BYPASS_ARB_EPOCH_ONCE_EN
    chk("ep_g3", a_if.GRANT, 4'b0000);
    next();
    chk("ep_g4", a_if.GRANT, 4'b0000);
    chk("ep_count3", a_if.EPOCH_COUNT, 3'd2);
`else
    chk("ep_g3", a_if.GRANT, 4'b0001);
    next();
    chk("ep_g4", a_if.GRANT, 4'b0010);
    chk("ep_count3", a_if.EPOCH_COUNT, 3'd3);
`endif
    a_if.EPOCH_END = 1'b1;
    next();
    a_if.EPOCH_END = 1'b0;
    #1;
    chk("ep_clr_served", a_if.SERVED, 4'b0000);
    chk("ep_clr_count",  a_if.EPOCH_COUNT, 3'd0);
    chk("ep_g5",         a_if.GRANT, 4'b0001);

    // Grant coinciding with epoch end
    reset_a();
    a_if.REQ = 4'b0001;
    #1;
    chk("sim_g0", a_if.GRANT, 4'b0001);
    next();
    chk("sim_count1", a_if.EPOCH_COUNT, 3'd1);
    a_if.REQ       = 4'b0100;
    a_if.EPOCH_END = 1'b1;
    #1;
    chk("sim_grant", a_if.GRANT, 4'b0100);
    chk("sim_enq",   a_if.FIFO_ENQ, 1'b1);
    chk("sim_value", a_if.FIFO_ENQ_VALUE, 8'h33);
    next();
    a_if.EPOCH_END = 1'b0;
    a_if.REQ       = 4'b1111;
    #1;
    chk("sim_served", a_if.SERVED, 4'b0000);
    chk("sim_count",  a_if.EPOCH_COUNT, 3'd0);
    chk("sim_prio3",  a_if.GRANT, 4'b1000);
    chk("sim_value3", a_if.FIFO_ENQ_VALUE, 8'h44);

    // Asynchronous reset while requester 2 is granted
    next();
    a_if.REQ = 4'b0100;
    #1;
    chk("ar_pre_grant",  a_if.GRANT, 4'b0100);
    chk("ar_pre_served", a_if.SERVED, 4'b1000);
    rst_a = 1'b1;
    #1;
    chk("ar_grant",  a_if.GRANT, 4'b0000);
    chk("ar_enq",    a_if.FIFO_ENQ, 1'b0);
    chk("ar_value",  a_if.FIFO_ENQ_VALUE, 8'h00);
    chk("ar_served", a_if.SERVED, 4'b0000);
    chk("ar_count",  a_if.EPOCH_COUNT, 3'd0);
    @(posedge clk);
    #1;
    rst_a    = 1'b0;
    a_if.REQ = 4'b1111;
    #1;
    chk("ar_restart", a_if.GRANT, 4'b0001);

    // Two requesters, ten cycles, no epoch end: counter saturation
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      exp_g2 = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_c  = (k > 3) ? 32'd3 : 32'(k);
`ifdef BYPASS_ARB_EPOCH_ONCE_EN
      if (k >= 2) exp_g2 = 2'b00;
      exp_c = (k > 2) ? 32'd2 : 32'(k);
`endif
      chk("sat_grant", b_if.GRANT, exp_g2);
      chk("sat_value", b_if.FIFO_ENQ_VALUE,
          (exp_g2 == 2'b01) ? 4'hA : (exp_g2 == 2'b10) ? 4'hB : 4'h0);
      chk("sat_count", b_if.EPOCH_COUNT, exp_c);
      next();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
